// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory arbiter slice.
package dmem_pkg;

    localparam int unsigned DEF_AW = 10;
    localparam int unsigned DEF_DW = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the port not granted most recently wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 when port 1 holds the most recent grant; reset value hands p0 the first tie
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (advance) begin
            if (req[0] && (!req[1] || last)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port SRAM between a fetch port and a load/store port,
// zero-filling the memory after reset before any request is served.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          init_done
);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic [1:0]    gnt;
    logic          run_en;

    // Grants are withheld during reset so a read in that cycle never reports back
    assign run_en = (state == RUN) && !rst;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({p1_req, p0_req}),
        .advance (run_en),
        .gnt     (gnt)
    );

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign init_done = (state == RUN);

    // SRAM port mux; the address is held when idle to avoid needless toggling
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = cnt;
        end else if (gnt[0]) begin
            mem_addr  = p0_addr;
            mem_wdata = p1_wdata;
        end else if (gnt[1]) begin
            mem_addr  = p1_addr;
            mem_we    = p1_we;
            mem_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            cnt       <= '0;
            addr_q    <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            addr_q    <= mem_addr;
            p0_rvalid <= gnt[0];
            p1_rvalid <= gnt[1] & ~p1_we;
            if (gnt[0]) begin
                p0_rdata <= mem_rdata;
            end
            if (gnt[1] && !p1_we) begin
                p1_rdata <= mem_rdata;
            end
            if (state == CLEAR) begin
                cnt <= cnt + AW'(1);
                if (cnt == '1) begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level memory/arbitration model.
module tb_dmem_arbiter;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          p0_req;
    logic [AW-1:0] p0_addr;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          init_done;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_addr   (p0_addr),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read, write on the clock edge
    logic [DW-1:0] sram [0:DEPTH-1];
    assign mem_rdata = sram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state: memory contents, most recent winner, pending read results
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    int            prev_port;
    logic [AW-1:0] exp_addr;
    logic          exp_rv0, exp_rv1;
    logic [DW-1:0] exp_rd0, exp_rd1;
    logic          g0, g1;

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        prev_port = 1;
        exp_addr  = AW'(DEPTH - 1);
        exp_rv0   = 1'b0;
        exp_rv1   = 1'b0;
        exp_rd0   = '0;
        exp_rd1   = '0;
    endtask

    // One RUN-mode cycle: verify last cycle's read results, present requests, verify grants
    task automatic cycle(input logic r0, input logic [AW-1:0] a0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1, output logic g0o, output logic g1o);
        logic eg0, eg1;
        @(negedge clk);
        chk("p0_rvalid", p0_rvalid, exp_rv0);
        chk("p0_rdata", p0_rdata, exp_rd0);
        chk("p1_rvalid", p1_rvalid, exp_rv1);
        chk("p1_rdata", p1_rdata, exp_rd1);
        p0_req = r0; p0_addr = a0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #1;
        eg0 = r0 && (!r1 || prev_port == 1);
        eg1 = r1 && !eg0;
        chk("p0_gnt", p0_gnt, eg0);
        chk("p1_gnt", p1_gnt, eg1);
        if (eg0) exp_addr = a0;
        if (eg1) exp_addr = a1;
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", mem_we, eg1 && w1);
        if (eg1) chk("mem_wdata", mem_wdata, d1);
        else if (!eg0) chk("mem_wdata_idle", mem_wdata, 0);
        exp_rv0 = eg0;
        if (eg0) exp_rd0 = ref_mem[a0];
        exp_rv1 = eg1 && !w1;
        if (eg1 && !w1) exp_rd1 = ref_mem[a1];
        if (eg1 && w1) ref_mem[a1] = d1;
        if (eg0) prev_port = 0;
        if (eg1) prev_port = 1;
        g0o = eg0;
        g1o = eg1;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, g0, g1);
    endtask

    // Called right after rst drops at a falling edge; walks the whole zero-fill
    task automatic clear_check();
        int bad_mem, bad_gnt, bad_done;
        bad_mem = 0; bad_gnt = 0; bad_done = 0;
        for (int i = 0; i < DEPTH; i++) begin
            p0_req = 1'($urandom_range(0, 1));
            p1_req = 1'($urandom_range(0, 1));
            p1_we  = 1'($urandom_range(0, 1));
            p0_addr = AW'($urandom); p1_addr = AW'($urandom); p1_wdata = $urandom;
            #1;
            if (i == 0) chk("clear_first_addr", mem_addr, 0);
            if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== '0) bad_mem++;
            if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) bad_gnt++;
            if (init_done !== 1'b0) bad_done++;
            @(negedge clk);
        end
        p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
        #1;
        chk("clear_bad_writes", bad_mem, 0);
        chk("clear_bad_grants", bad_gnt, 0);
        chk("clear_early_done", bad_done, 0);
        chk("clear_init_done", init_done, 1);
        chk("clear_stops", mem_we, 0);
        reset_model();
    endtask

    logic          act0, act1, rw1;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] rd1;

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return AW'(DEPTH - 1);
        return AW'($urandom_range(0, 15));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        p0_req = 1'b0; p0_addr = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        chk("rst_init_done", init_done, 0);
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        rst = 1'b0;
        clear_check();

        // Both ports contend: strict alternation starting with p0
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, AW'(i), 1'b1, 1'b0, AW'(i + 8), '0, g0, g1);
            chk("cont_p1_gnt", p1_gnt, (i % 2));
        end
        idle();

        // Single read of a known word
        cycle(1'b0, '0, 1'b1, 1'b1, AW'(5), 32'hDEADBEEF, g0, g1);
        cycle(1'b1, AW'(5), 1'b0, 1'b0, '0, '0, g0, g1);
        chk("single_p0_gnt", p0_gnt, 1);
        idle();
        chk("single_rvalid", p0_rvalid, 1);
        chk("single_rdata", p0_rdata, 32'hDEADBEEF);

        // Write top address then read it back
        cycle(1'b0, '0, 1'b1, 1'b1, AW'(DEPTH - 1), 32'h12345678, g0, g1);
        cycle(1'b1, AW'(DEPTH - 1), 1'b0, 1'b0, '0, '0, g0, g1);
        chk("wr_no_p1_rvalid", p1_rvalid, 0);
        idle();
        chk("wr_rd_rdata", p0_rdata, 32'h12345678);

        // Random traffic; each requester holds its request until granted
        act0 = 1'b0; act1 = 1'b0; ra0 = '0; ra1 = '0; rw1 = 1'b0; rd1 = '0;
        for (int n = 0; n < 500; n++) begin
            if (!act0 && $urandom_range(0, 3) != 0) begin
                act0 = 1'b1; ra0 = rand_addr();
            end
            if (!act1 && $urandom_range(0, 3) != 0) begin
                act1 = 1'b1; ra1 = rand_addr();
                rw1 = 1'($urandom_range(0, 1)); rd1 = $urandom;
            end
            cycle(act0, ra0, act1, rw1, ra1, rd1, g0, g1);
            if (g0) act0 = 1'b0;
            if (g1) act1 = 1'b0;
        end
        idle();

        // Reset during a read request: nothing reported, clear restarts at 0
        @(negedge clk);
        p0_req = 1'b1; p0_addr = AW'(5); p1_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; p0_req = 1'b0;
        chk("mrst_p0_rvalid", p0_rvalid, 0);
        chk("mrst_p1_rvalid", p1_rvalid, 0);
        chk("mrst_init_done", init_done, 0);
        chk("mrst_p0_rdata", p0_rdata, 0);
        clear_check();

        // Previously written word now reads back cleared
        cycle(1'b1, AW'(5), 1'b0, 1'b0, '0, '0, g0, g1);
        idle();
        chk("cleared_rvalid", p0_rvalid, 1);
        chk("cleared_rdata", p0_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
